// File: rtl/soft_processor_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// control/status bit positions and the bus address width helper.
package soft_processor_multi_timer_pkg;

  // Register offsets inside one channel bank
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_IRQ_PEND = 3'd7;

  // STATUS bits
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  // CONTROL bits
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Address is {channel, reg[2:0]}; a single channel needs no channel bits.
  function automatic int addr_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) + 3 : 3;
  endfunction

endpackage

// File: rtl/soft_processor_timer_channel.sv
// One timer channel: configuration registers, prescaler, down-counter,
// TO/RUN status and snapshot capture. Reads are combinational; the top
// registers the selected value.
module soft_processor_timer_channel
  import soft_processor_multi_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int PRE_W          = 16,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int                HI_W         = CNT_W - 16;
  localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] snapshot;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       control;
  logic             to_flag;
  logic             run;
  logic             force_reload;

  logic wr_status, wr_control, wr_period_l, wr_period_h, wr_snap, wr_prescale;
  logic start_req, stop_req, tick, timeout;

  assign wr_status   = wr_en && (reg_sel == REG_STATUS);
  assign wr_control  = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period_l = wr_en && (reg_sel == REG_PERIOD_L);
  assign wr_period_h = wr_en && (reg_sel == REG_PERIOD_H);
  assign wr_snap     = wr_en && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
  assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);

  assign start_req = wr_control && wdata[CTRL_START];
  assign stop_req  = wr_control && wdata[CTRL_STOP];

  // A tick fires when the running prescaler has drained; the cycle that
  // applies a forced reload never counts as a timeout.
  assign tick    = run && (pre_cnt == '0);
  assign timeout = tick && (counter == '0) && !force_reload;

  assign irq = to_flag && control[CTRL_ITO];

  // Configuration registers and the one-cycle force-reload pulse after a period write.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= RESET_PERIOD;
      prescale     <= '0;
      control      <= '0;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_period_l || wr_period_h;
      if (wr_period_l) period[15:0]       <= wdata;
      if (wr_period_h) period[CNT_W-1:16] <= wdata[HI_W-1:0];
      if (wr_prescale) prescale           <= wdata[PRE_W-1:0];
      if (wr_control)  control            <= wdata[3:0];
    end
  end

  // Prescaler: parked at PRESCALE while stopped, otherwise counts down and reloads on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (force_reload || !run || tick) begin
      pre_cnt <= prescale;
    end else begin
      pre_cnt <= pre_cnt - PRE_W'(1);
    end
  end

  // Main down-counter: forced reload wins, otherwise decrement per tick and wrap to period at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= RESET_PERIOD;
    end else if (force_reload) begin
      counter <= period;
    end else if (tick) begin
      counter <= (counter == '0) ? period : counter - CNT_W'(1);
    end
  end

  // TO and RUN flags: a timeout beats a same-cycle clear, START beats everything that stops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_flag <= 1'b0;
      run     <= 1'b0;
    end else begin
      if (timeout)        to_flag <= 1'b1;
      else if (wr_status) to_flag <= 1'b0;

      if (start_req)                           run <= 1'b1;
      else if (stop_req || force_reload)       run <= 1'b0;
      else if (timeout && !control[CTRL_CONT]) run <= 1'b0;
    end
  end

  // Snapshot captures the counter as it stands before this edge's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot <= '0;
    end else if (wr_snap) begin
      snapshot <= counter;
    end
  end

  // Register read mux for this channel; IRQ_PEND is assembled by the top.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves rdata unassigned (no latch).
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[STATUS_TO]  = to_flag;
        rdata[STATUS_RUN] = run;
      end
      REG_CONTROL:  rdata[3:0]       = control;
      REG_PERIOD_L: rdata            = period[15:0];
      REG_PERIOD_H: rdata[HI_W-1:0]  = period[CNT_W-1:16];
      REG_SNAP_L:   rdata            = snapshot[15:0];
      REG_SNAP_H:   rdata[HI_W-1:0]  = snapshot[CNT_W-1:16];
      REG_PRESCALE: rdata[PRE_W-1:0] = prescale;
      default:      rdata            = '0;
    endcase
  end

endmodule

// File: rtl/soft_processor_multi_timer.sv
// Multi-channel interval timer on the Avalon-MM slave bus: address decode,
// registered read mux and interrupt combining around NUM_CH channels.
module soft_processor_multi_timer
  import soft_processor_multi_timer_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int PRE_W          = 16,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [addr_w(NUM_CH)-1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [15:0]               writedata,
  output logic [15:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec
);

  localparam int ADDR_W = addr_w(NUM_CH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [2:0]      reg_sel;
  logic [CH_W-1:0] ch_idx;
  logic            ch_valid;
  logic            wr_stb;
  logic [15:0]     ch_rdata [NUM_CH];
  logic [15:0]     rd_mux;

  assign reg_sel = address[2:0];
  assign wr_stb  = chipselect && !write_n;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch_idx = address[ADDR_W-1:3];
    end else begin : g_single
      assign ch_idx = '0;
    end
  endgenerate

  // Banks beyond NUM_CH (possible when NUM_CH is not a power of two) are dead.
  assign ch_valid = int'(ch_idx) < NUM_CH;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      soft_processor_timer_channel #(
        .CNT_W          (CNT_W),
        .PRE_W          (PRE_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_channel (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_stb && ch_valid && (int'(ch_idx) == i)),
        .reg_sel (reg_sel),
        .wdata   (writedata),
        .rdata   (ch_rdata[i]),
        .irq     (irq_vec[i])
      );
    end
  endgenerate

  assign irq = |irq_vec;

  // Select the addressed register; IRQ_PEND mirrors irq_vec in every valid bank.
  always_comb begin
    rd_mux = '0;
    if (ch_valid) begin
      if (reg_sel == REG_IRQ_PEND) begin
        rd_mux = 16'(irq_vec);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (int'(ch_idx) == i) rd_mux = ch_rdata[i];
        end
      end
    end
  end

  // Read data register, refreshed every clock independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: doc/soft_processor_multi_timer.md
Name: soft_processor_multi_timer

Overview:
Parametrised multi-channel interval timer on the soft-processor Avalon-MM bus. It provides NUM_CH independent down-counters, each CNT_W bits wide with its own prescaler. Each channel supports one-shot or continuous mode, snapshot capture and a per-channel interrupt. Channel interrupts are exposed individually and ORed onto a single irq for the processor.

Parameters:
NUM_CH, 2, number of timer channels (1..4)
CNT_W, 32, counter/period width in bits (17..32); period_h holds bits CNT_W-1:16
PRE_W, 16, prescaler width in bits (1..16)
DEFAULT_PERIOD, 49999, reset value of period and counter in every channel

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  $clog2(NUM_CH)+3  {channel, reg[2:0]}; NUM_CH=1 gives 3 bits
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  OR of irq_vec
irq_vec  out  NUM_CH  per-channel interrupt (TO & ITO)

Behaviour:
- Register map per channel, reg offset:
  - 0 STATUS: bit0 TO, bit1 RUN; any write clears TO
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP; stores bits 3:0
  - 2 PERIOD_L; 3 PERIOD_H (bits CNT_W-17:0 used, upper bits read 0)
  - 4 SNAP_L; 5 SNAP_H: any write captures counter; reads return the capture
  - 6 PRESCALE: tick every PRESCALE+1 clocks, PRE_W bits used
  - 7 IRQ_PEND: read returns irq_vec zero-extended in every bank; writes ignored
- Channel index >= NUM_CH: reads return 0, writes ignored.
- Write strobe = chipselect & ~write_n. Reads: readdata updates every clock from the addressed register, regardless of chipselect (1-cycle latency).
- Reset values:
  - counter = period = DEFAULT_PERIOD; prescale = 0; control = 0
  - TO = RUN = 0; snapshot = 0; readdata = 0; irq = 0; irq_vec = 0
- Prescaler:
  - Down-counter; tick asserts when it is 0 and RUN=1, then it reloads PRESCALE.
  - Held at PRESCALE while RUN=0.
- Counter, on tick:
  - If counter==0: load period, set TO; if CONT=0 clear RUN.
  - Otherwise decrement.
  - Result: timeout every (period+1)*(PRESCALE+1) clocks.
- Force reload:
  - A write to PERIOD_L/H registers force_reload for one cycle.
  - Next cycle: counter <= new period, prescaler <= PRESCALE, RUN <= 0.
- START write sets RUN next cycle. STOP clears it. START and STOP together: START wins.
- force_reload cycle and START write in the same cycle: START wins.
- TO clear and timeout event in the same cycle: set wins, so no event is lost.
- period=0 with CONT=1: TO sets on every tick. With CONT=0: one timeout, then stop.
- Snapshot write coinciding with a decrement captures the pre-decrement value.
- irq_vec[i] = TO_i & ITO_i, combinational from registers. irq = |irq_vec.
- Reset asserted mid-count: all state returns to reset values immediately.

Decomposition:
- Package soft_processor_multi_timer_pkg:
  - register offset constants (REG_STATUS..REG_IRQ_PEND)
  - control/status bit indices
  - localparam ADDR_W function
- Sub-module soft_processor_timer_channel, instantiated NUM_CH times. It holds:
  - channel registers
  - prescaler, counter, TO/RUN
  - snapshot
- The top holds only address decode, read mux, readdata register and the irq OR.

Test Plan:
- Reset → readdata=0, irq=0. PERIOD_L reads 49999 (0xC34F), PRESCALE reads 0, STATUS reads 0 for each channel.
- Ch0: PERIOD_L=4, PERIOD_H=0, CONTROL=0x7 (ITO|CONT|START), PRESCALE=0 → TO and irq_vec[0] first set 5 clocks after RUN rises, then every 5 clocks after STATUS clears. irq_vec[1]=0 throughout.
- Ch1: PERIOD_L=2, PRESCALE=3, CONTROL=0x5 (one-shot) → TO after 12 clocks, then RUN=0, counter reads 2 via snapshot, no further timeouts.
- Ch0 running: write STATUS in the same cycle TO would set → TO remains 1. Write CONTROL=0xC → RUN=1 (START wins).
- Ch0 running: write PERIOD_H=1 → RUN=0 next cycle. Snapshot reads SNAP_H=1, SNAP_L=PERIOD_L value.
- Both channels timing out with ITO=1 → IRQ_PEND reads 0x3 and irq=1. Clear ch0 STATUS → IRQ_PEND=0x2, irq stays 1. Assert reset_n=0 mid-count → all outputs 0 asynchronously.
